// File: rtl/stack_xfer_seq_pkg.sv
// Shared bus select codes, slot/state enums and the postbyte-to-slot expansion
// used by the 6809 stack transfer sequencer.
package stack_xfer_seq_pkg;

    localparam logic [3:0] AB_NONE = 4'd0;
    localparam logic [3:0] AB_PC   = 4'd1;
    localparam logic [3:0] AB_SP   = 4'd2;
    localparam logic [3:0] AB_US   = 4'd3;
    localparam logic [3:0] AB_X    = 4'd4;
    localparam logic [3:0] AB_Y    = 4'd5;
    localparam logic [3:0] AB_AR   = 4'd6;

    localparam logic [4:0] DB_NONE = 5'd0;
    localparam logic [4:0] DB_CC   = 5'd1;
    localparam logic [4:0] DB_A    = 5'd2;
    localparam logic [4:0] DB_B    = 5'd3;
    localparam logic [4:0] DB_DP   = 5'd4;
    localparam logic [4:0] DB_XH   = 5'd5;
    localparam logic [4:0] DB_XL   = 5'd6;
    localparam logic [4:0] DB_YH   = 5'd7;
    localparam logic [4:0] DB_YL   = 5'd8;
    localparam logic [4:0] DB_USH  = 5'd9;
    localparam logic [4:0] DB_USL  = 5'd10;
    localparam logic [4:0] DB_SPH  = 5'd11;
    localparam logic [4:0] DB_SPL  = 5'd12;
    localparam logic [4:0] DB_ARH  = 5'd13;
    localparam logic [4:0] DB_ARL  = 5'd14;
    localparam logic [4:0] DB_MEM  = 5'd15;

    localparam int NUM_SLOTS = 11;

    // Slots are numbered in pull order (lowest stack address first).
    typedef enum logic [3:0] {
        SL_CC, SL_A, SL_B, SL_XH, SL_XL, SL_YH, SL_YL,
        SL_OTHH, SL_OTHL, SL_PCH, SL_PCL
    } slot_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_WRITE, ST_READ, ST_MOVEPC, ST_EMPTY
    } state_e;

    // DP (b3) has no data-bus path and never becomes a slot.
    function automatic logic [NUM_SLOTS-1:0] mask_to_slots(input logic [7:0] m);
        logic [NUM_SLOTS-1:0] s;
        s          = '0;
        s[SL_CC]   = m[0];
        s[SL_A]    = m[1];
        s[SL_B]    = m[2];
        s[SL_XH]   = m[4];
        s[SL_XL]   = m[4];
        s[SL_YH]   = m[5];
        s[SL_YL]   = m[5];
        s[SL_OTHH] = m[6];
        s[SL_OTHL] = m[6];
        s[SL_PCH]  = m[7];
        s[SL_PCL]  = m[7];
        return s;
    endfunction

endpackage

// File: rtl/stack_xfer_seq_slot_pick.sv
// Priority encoder over the remaining slots: lowest slot first when pulling,
// highest first when pushing, plus the slot's data-bus code and a last flag.
module stack_slot_pick
    import stack_xfer_seq_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] remaining,
    input  logic                 pull,
    input  logic                 use_u,
    output logic [3:0]           slot,
    output logic [4:0]           db_code,
    output logic                 last
);

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        slot = SL_CC;
        if (pull) begin
            for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
                if (remaining[i]) slot = 4'(i);
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (remaining[i]) slot = 4'(i);
            end
        end
    end

    always_comb begin
        db_code = DB_NONE;
        case (slot)
            SL_CC:   db_code = DB_CC;
            SL_A:    db_code = DB_A;
            SL_B:    db_code = DB_B;
            SL_XH:   db_code = DB_XH;
            SL_XL:   db_code = DB_XL;
            SL_YH:   db_code = DB_YH;
            SL_YL:   db_code = DB_YL;
            SL_OTHH: db_code = use_u ? DB_SPH : DB_USH;
            SL_OTHL: db_code = use_u ? DB_SPL : DB_USL;
            SL_PCH:  db_code = DB_ARH;
            SL_PCL:  db_code = DB_ARL;
            default: db_code = DB_NONE;
        endcase
    end

    assign last = ((remaining & ~(NUM_SLOTS'(1) << slot)) == '0);

endmodule

// File: rtl/stack_xfer_seq.sv
// 6809 PSHS/PSHU/PULS/PULU sequencer: walks the postbyte register list one memory
// byte per cycle and drives Moore-decoded datapath select, strobe and inc/dec codes.
module stack_xfer_seq
    import stack_xfer_seq_pkg::*;
#(
    parameter int AB_SEL_W = 4,
    parameter int DB_SEL_W = 5,
    parameter int FAB_W    = 16,
    parameter int FDB_W    = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                pull,
    input  logic                use_u,
    input  logic [7:0]          mask,
    output logic                busy,
    output logic                done,
    output logic                dp_skipped,
    output logic [AB_SEL_W-1:0] output_on_ab,
    output logic [DB_SEL_W-1:0] output_on_db,
    output logic [FAB_W-1:0]    fetch_from_ab,
    output logic [FDB_W-1:0]    fetch_from_db,
    output logic [AB_SEL_W-1:0] inc,
    output logic [AB_SEL_W-1:0] dec
);

    state_e               state_q, state_d;
    logic [NUM_SLOTS-1:0] rem_q, rem_d;
    logic                 pull_q, pull_d;
    logic                 use_u_q, use_u_d;
    logic                 pc_q, pc_d;
    logic                 dp_q, dp_d;

    logic [3:0]           slot;
    logic [4:0]           slot_db;
    logic                 slot_last;
    logic [3:0]           stk;
    logic [NUM_SLOTS-1:0] start_slots;

    stack_slot_pick u_pick (
        .remaining (rem_q),
        .pull      (pull_q),
        .use_u     (use_u_q),
        .slot      (slot),
        .db_code   (slot_db),
        .last      (slot_last)
    );

    assign stk         = use_u_q ? AB_US : AB_SP;
    assign start_slots = mask_to_slots(mask);

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        pull_d        = pull_q;
        use_u_d       = use_u_q;
        pc_d          = pc_q;
        dp_d          = dp_q;
        done          = 1'b0;
        output_on_ab  = '0;
        output_on_db  = '0;
        fetch_from_ab = '0;
        fetch_from_db = '0;
        inc           = '0;
        dec           = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pull_d  = pull;
                    use_u_d = use_u;
                    pc_d    = mask[7];
                    dp_d    = mask[3];
                    rem_d   = start_slots;
                    if (start_slots == '0) state_d = ST_EMPTY;
                    else if (pull)         state_d = ST_READ;
                    else                   state_d = ST_PRE;
                end
            end
            // PC is staged into AR here so the WRITE cycles can source its bytes from AR.
            ST_PRE: begin
                dec = stk;
                if (pc_q) begin
                    output_on_ab         = AB_PC;
                    fetch_from_ab[AB_AR] = 1'b1;
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                output_on_ab          = stk;
                output_on_db          = slot_db;
                fetch_from_db[DB_MEM] = 1'b1;
                rem_d                 = rem_q & ~(NUM_SLOTS'(1) << slot);
                if (slot_last) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    dec = stk;
                end
            end
            ST_READ: begin
                output_on_ab           = stk;
                output_on_db           = DB_MEM;
                fetch_from_db[slot_db] = 1'b1;
                inc                    = stk;
                rem_d                  = rem_q & ~(NUM_SLOTS'(1) << slot);
                if (slot_last) begin
                    done    = !pc_q;
                    state_d = pc_q ? ST_MOVEPC : ST_IDLE;
                end
            end
            ST_MOVEPC: begin
                output_on_ab         = AB_AR;
                fetch_from_ab[AB_PC] = 1'b1;
                done                 = 1'b1;
                state_d              = ST_IDLE;
            end
            ST_EMPTY: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            pull_q  <= 1'b0;
            use_u_q <= 1'b0;
            pc_q    <= 1'b0;
            dp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pull_q  <= pull_d;
            use_u_q <= use_u_d;
            pc_q    <= pc_d;
            dp_q    <= dp_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign dp_skipped = dp_q;

endmodule
